// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the unified instruction/data memory.
// m0 = CPU port, m1 = loader/debug port; round-robin on conflict,
// fixed-latency access, one-cycle ack with captured read data.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                last_gnt, last_gnt_n;
  logic                owner, owner_n;
  logic                we_reg, we_reg_n;
  logic [ADDR_W-1:0]   addr_reg, addr_reg_n;
  logic [DATA_W-1:0]   wdata_reg, wdata_reg_n;
  logic [DATA_W-1:0]   rdata_reg, rdata_reg_n;
  logic                m0_ack_n, m1_ack_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic                mem_we_n, mem_re_n, busy_n;
  logic                win;

  assign m0_rdata = rdata_reg;
  assign m1_rdata = rdata_reg;

  // State and registered outputs; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      owner     <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last_gnt  <= last_gnt_n;
      owner     <= owner_n;
      we_reg    <= we_reg_n;
      addr_reg  <= addr_reg_n;
      wdata_reg <= wdata_reg_n;
      rdata_reg <= rdata_reg_n;
      m0_ack    <= m0_ack_n;
      m1_ack    <= m1_ack_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_we    <= mem_we_n;
      mem_re    <= mem_re_n;
      busy      <= busy_n;
    end
  end

  // Next state; memory outputs are precomputed for the cycle being entered.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_gnt_n  = last_gnt;
    owner_n     = owner;
    we_reg_n    = we_reg;
    addr_reg_n  = addr_reg;
    wdata_reg_n = wdata_reg;
    rdata_reg_n = rdata_reg;
    m0_ack_n    = 1'b0;
    m1_ack_n    = 1'b0;
    mem_addr_n  = '0;
    mem_wdata_n = '0;
    mem_we_n    = 1'b0;
    mem_re_n    = 1'b0;
    // m1 wins if alone, or on conflict when m0 had the last grant
    win         = m1_req & (~m0_req | ~last_gnt);

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_n     = win;
          last_gnt_n  = win;
          cnt_n       = '0;
          we_reg_n    = win ? m1_we    : m0_we;
          addr_reg_n  = win ? m1_addr  : m0_addr;
          wdata_reg_n = win ? m1_wdata : m0_wdata;
          state_n     = ACCESS;
          mem_addr_n  = addr_reg_n;
          mem_wdata_n = wdata_reg_n;
          mem_we_n    = we_reg_n;
          mem_re_n    = ~we_reg_n;
        end
      end
      ACCESS: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          if (!we_reg) rdata_reg_n = mem_rdata;
          m0_ack_n = ~owner;
          m1_ack_n = owner;
          state_n  = RESP;
        end else begin
          // write strobe only in the first cycle; read enable held throughout
          mem_addr_n  = addr_reg;
          mem_wdata_n = wdata_reg;
          mem_re_n    = ~we_reg;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LAT=2.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  localparam int MODE_HOLD  = 0;
  localparam int MODE_REARM = 1;
  localparam int MODE_DROP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int re_cnt = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory model: data is valid only in the last ACCESS cycle of a read.
  always @(posedge clk) re_cnt <= mem_re ? re_cnt + 1 : 0;
  always_comb mem_rdata = (mem_re && re_cnt == LAT - 1) ? model(mem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit port, input logic v);
    if (port) m1_req = v; else m0_req = v;
  endtask

  // One read transaction on `port`, starting with the DUT in IDLE before the granting edge.
  task automatic serve(input bit port, input logic [AW-1:0] addr, input int mode);
    if (port) begin m1_we = 1'b0; m1_addr = addr; m1_req = 1'b1; end
    else      begin m0_we = 1'b0; m0_addr = addr; m0_req = 1'b1; end
    @(negedge clk);
    check($sformatf("acc1_addr_p%0d", port), mem_addr, addr);
    check("acc1_re", mem_re, 1);
    check("acc1_busy", busy, 1);
    @(negedge clk);
    check("acc2_re", mem_re, 1);
    check("acc2_ack0", m0_ack, 0);
    @(negedge clk);
    check($sformatf("resp_ack0_p%0d", port), m0_ack, port == 1'b0);
    check($sformatf("resp_ack1_p%0d", port), m1_ack, port == 1'b1);
    check("resp_rdata", port ? m1_rdata : m0_rdata, model(addr));
    check("resp_re", mem_re, 0);
    check("resp_busy", busy, 1);
    if (mode != MODE_HOLD) set_req(port, 1'b0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ack", m0_ack | m1_ack, 0);
    if (mode == MODE_REARM) set_req(port, 1'b1);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", {m0_ack, m1_ack}, 0);
    check("rst_mem", {mem_we, mem_re}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", m0_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // 1: m0 read from 0x40
    serve(1'b0, 32'h40, MODE_DROP);

    // 2: m1 write, rdata must stay
    m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'h1234_5678; m1_req = 1'b1;
    @(negedge clk);
    check("wr_we1", mem_we, 1);
    check("wr_re1", mem_re, 0);
    check("wr_addr", mem_addr, 32'h10);
    check("wr_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    check("wr_we2", mem_we, 0);
    check("wr_re2", mem_re, 0);
    check("wr_addr2", mem_addr, 32'h10);
    @(negedge clk);
    check("wr_ack1", m1_ack, 1);
    check("wr_ack0", m0_ack, 0);
    check("wr_rdata_hold", m1_rdata, 32'hDEAD_BEEF);
    check("wr_resp_addr", mem_addr, 0);
    m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clk);
    check("wr_idle_busy", busy, 0);
    check("wr_idle_ack", m1_ack, 0);

    // 3: continuous conflict after reset alternates m0, m1, m0, m1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_addr = 32'h100; m1_addr = 32'h200; m0_req = 1'b1; m1_req = 1'b1;
    serve(1'b0, 32'h100, MODE_REARM);
    serve(1'b1, 32'h200, MODE_REARM);
    serve(1'b0, 32'h100, MODE_REARM);
    serve(1'b1, 32'h200, MODE_DROP);
    m0_req = 1'b0;
    @(negedge clk);
    check("rr_quiet", busy, 0);

    // 4: m0 held, served every LAT+2 cycles
    serve(1'b0, 32'h300, MODE_HOLD);
    serve(1'b0, 32'h300, MODE_HOLD);
    serve(1'b0, 32'h300, MODE_DROP);

    // 5: reset during first ACCESS cycle of a write
    m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hCAFE_F00D; m1_req = 1'b1;
    @(negedge clk);
    check("abort_we_pre", mem_we, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_we", mem_we, 0);
    check("abort_re", mem_re, 0);
    check("abort_busy", busy, 0);
    check("abort_rdata", m1_rdata, 0);
    m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clk);
    check("abort_ack_a", m1_ack, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ack_b", {m0_ack, m1_ack}, 0);
    check("abort_idle", busy, 0);
    m0_addr = 32'h44; m1_addr = 32'h48; m0_req = 1'b1; m1_req = 1'b1;
    serve(1'b0, 32'h44, MODE_DROP);
    serve(1'b1, 32'h48, MODE_DROP);

    // 6: m0 drops req right after grant
    m0_we = 1'b0; m0_addr = 32'h80; m0_req = 1'b1;
    @(negedge clk);
    check("drop_addr", mem_addr, 32'h80);
    m0_req = 1'b0;
    @(negedge clk);
    check("drop_re", mem_re, 1);
    @(negedge clk);
    check("drop_ack", m0_ack, 1);
    check("drop_rdata", m0_rdata, model(32'h80));
    @(negedge clk);
    check("drop_idle1", busy, 0);
    @(negedge clk);
    check("drop_idle2", busy, 0);
    check("drop_idle_re", mem_re, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
